fetch_stage: RTL and testbench

Instruction-fetch stage of the MIPS pipeline, directly upstream of the combinational program memory. Holds the program counter and drives the memory's byte address. Captures the returned instruction into the IF/ID pipeline register with a valid/ready handshake toward decode. Accepts branch/jump redirects and counts retired fetches.

---
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID register with valid/ready handshake, redirects.
// Optional FETCH_MISALIGN_TRAP_EN: a misaligned redirect raises a sticky fault and freezes fetch.
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0040_0000)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] imem_address,
    input  logic [DATA_WIDTH-1:0] imem_instruction,
    input  logic                  redirect,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    input  logic                  id_ready,
    output logic                  if_id_valid,
    output logic [DATA_WIDTH-1:0] if_id_instruction,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [31:0]           fetch_count,
    output logic                  misalign_fault
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic [31:0]           count_q, count_d;
    logic                  fault_q, fault_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] aligned_target;
    logic                  bad_target;

    assign pc_plus4       = pc_q + DATA_WIDTH'(4);
    assign aligned_target = redirect_target & ~DATA_WIDTH'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bad_target     = (redirect_target[1:0] != 2'b00);
    assign misalign_fault = fault_q;
`else
    assign bad_target     = 1'b0;
    assign misalign_fault = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        fault_d = fault_q;
        // An accepted instruction counts even if a redirect lands on the same edge.
        count_d = (valid_q && id_ready) ? count_q + 32'd1 : count_q;
        if (fault_q) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc4_d   = '0;
        end else if (redirect) begin
            valid_d = 1'b0;
            instr_d = '0;
            pc4_d   = '0;
            if (bad_target) begin
                fault_d = 1'b1;
            end else begin
                pc_d = aligned_target;
            end
        end else if (id_ready || !valid_q) begin
            pc_d    = pc_plus4;
            valid_d = 1'b1;
            instr_d = imem_instruction;
            pc4_d   = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign imem_address      = pc_q;
    assign pc                = pc_q;
    assign if_id_valid       = valid_q;
    assign if_id_instruction = instr_q;
    assign if_id_pc_plus4    = pc4_q;
    assign fetch_count       = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a rule-level fetch model checked every cycle, plus literal spot checks.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        id_ready;
    logic        if_id_valid;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] pc;
    logic [31:0] fetch_count;
    logic        misalign_fault;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Program memory: word index tagged so every word is distinct.
    function automatic logic [31:0] mem(input logic [31:0] addr);
        return 32'h1000_0000 + ((addr >> 2) - 32'h0010_0000);
    endfunction

    assign imem_instruction = mem(imem_address);

    fetch_stage dut (
        .clk               (clk),
        .reset             (reset),
        .imem_address      (imem_address),
        .imem_instruction  (imem_instruction),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .id_ready          (id_ready),
        .if_id_valid       (if_id_valid),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .pc                (pc),
        .fetch_count       (fetch_count),
        .misalign_fault    (misalign_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the stage must hold after each edge, from the operating rules.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_fault;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0040_0000; m_instr = 0; m_pc4 = 0; m_valid = 0; m_count = 0; m_fault = 0;
        end else begin
            if (m_valid && id_ready) m_count = m_count + 1;
            if (m_fault || redirect) begin
                m_valid = 0; m_instr = 0; m_pc4 = 0;
                if (!m_fault) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (redirect_target % 4 != 0) m_fault = 1;
                    else m_pc = redirect_target;
`else
                    m_pc = (redirect_target / 4) * 4;
`endif
                end
            end else if (!m_valid || id_ready) begin
                m_instr = mem(m_pc);
                m_pc    = m_pc + 4;
                m_pc4   = m_pc;
                m_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("imem_address", imem_address, m_pc);
            chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
            chk("if_id_instruction", if_id_instruction, m_instr);
            chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
            chk("fetch_count", fetch_count, m_count);
            chk("misalign_fault", 32'(misalign_fault), 32'(m_fault));
        end
    end

    task automatic step(input logic rst, input logic rdr, input logic [31:0] tgt,
                        input logic rdy);
        reset = rst; redirect = rdr; redirect_target = tgt; id_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; redirect = 0; redirect_target = 0; id_ready = 0;
        step(1, 0, 0, 0);
        chk_en = 1'b1;
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_valid", 32'(if_id_valid), 0);
        chk("rst_count", fetch_count, 0);

        // Straight-line fetch A..D.
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
        chk("adv_pc", pc, 32'h0040_0010);
        chk("adv_instr_d", if_id_instruction, 32'h1000_0003);
        chk("adv_pc4", if_id_pc_plus4, 32'h0040_0010);
        chk("adv_count", fetch_count, 3);

        // Stall with B in IF/ID, then resume to C.
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("stall_pc", pc, 32'h0040_0008);
        chk("stall_instr_b", if_id_instruction, 32'h1000_0001);
        step(0, 0, 0, 1);
        chk("resume_instr_c", if_id_instruction, 32'h1000_0002);
        chk("resume_pc4", if_id_pc_plus4, 32'h0040_000C);

        // Redirect while stalled.
        step(0, 0, 0, 0);
        step(0, 1, 32'h0040_0040, 0);
        chk("rdr_bubble", 32'(if_id_valid), 0);
        chk("rdr_pc", pc, 32'h0040_0040);
        step(0, 0, 0, 1);
        chk("rdr_word16", if_id_instruction, 32'h1000_0010);
        chk("rdr_pc4", if_id_pc_plus4, 32'h0040_0044);

        // PC wraps modulo 2^32.
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 1);
        chk("wrap_pc", pc, 32'h0000_0000);
        chk("wrap_pc4", if_id_pc_plus4, 32'h0000_0000);
        step(0, 0, 0, 1);

        // Reset during a redirect cycle wins.
        step(1, 1, 32'h1234_5678, 1);
        chk("rst_rdr_pc", pc, 32'h0040_0000);
        chk("rst_rdr_count", fetch_count, 0);

        // Misaligned redirect coinciding with a transfer.
        step(0, 0, 0, 1);
        step(0, 1, 32'h0040_0042, 1);
        chk("mis_count", fetch_count, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", 32'(misalign_fault), 1);
        chk("mis_pc", pc, 32'h0040_0004);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        chk("mis_frozen_pc", pc, 32'h0040_0004);
        chk("mis_frozen_valid", 32'(if_id_valid), 0);
`else
        chk("mis_fault", 32'(misalign_fault), 0);
        chk("mis_pc", pc, 32'h0040_0040);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
`endif
        step(1, 0, 0, 0);
        chk("final_rst_fault", 32'(misalign_fault), 0);
        chk("final_rst_pc", pc, 32'h0040_0000);
        step(0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
